// File: rtl/branch_redirect_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_unit_if
//  Description : Bundle of the fetch-side and resolve-side signals of the
//                branch redirect unit.
//                master : fetch/resolve environment (drives requests)
//                slave  : branch_redirect_unit (drives PC, flush, updates)
//  Ports       : stall, if_is_branch, pred_taken, if_target, res_valid,
//                res_taken                      (master -> slave)
//                pc, flush, upd_branch, upd_taken, q_full, err_underflow,
//                br_cnt, miss_cnt               (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_redirect_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // fetch / resolve requests
    logic              stall;
    logic              if_is_branch;
    logic              pred_taken;
    logic [ADDR_W-1:0] if_target;
    logic              res_valid;
    logic              res_taken;

    // unit responses
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              upd_branch;
    logic              upd_taken;
    logic              q_full;
    logic              err_underflow;
    logic [CNT_W-1:0]  br_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output stall, if_is_branch, pred_taken, if_target, res_valid, res_taken,
        input  pc, flush, upd_branch, upd_taken, q_full, err_underflow,
               br_cnt, miss_cnt
    );

    modport slave (
        input  stall, if_is_branch, pred_taken, if_target, res_valid, res_taken,
        output pc, flush, upd_branch, upd_taken, q_full, err_underflow,
               br_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_redirect_unit
//  Description : Owns the fetch program counter. Steers fetch to the
//                predicted target or fall-through, queues every in-flight
//                predicted branch with its alternate address, and on
//                resolution compares the actual outcome against the queued
//                prediction. A mismatch flushes younger work and redirects
//                the PC to the alternate address. The resolved outcome is
//                returned to the predictor as an update strobe/outcome pair.
//  Ports       : clk           - rising-edge clock
//                rst           - asynchronous active-high reset
//                bus.stall     - hazard stall, freezes PC and queue push
//                bus.if_is_branch / pred_taken / if_target
//                              - predecode + prediction for insn at pc
//                bus.res_valid / res_taken
//                              - oldest in-flight branch resolves
//                bus.pc        - registered fetch address
//                bus.flush     - mispredict, kill younger (combinational)
//                bus.upd_branch / upd_taken
//                              - predictor update pair (combinational)
//                bus.q_full    - queue holds DEPTH entries (registered)
//                bus.err_underflow
//                              - one-cycle pulse: resolve with empty queue
//                bus.br_cnt / miss_cnt
//                              - saturating resolve / mispredict counters
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_redirect_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_unit_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                  c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  c_QCNT_W  = c_PTR_W + 1;
    localparam logic [c_QCNT_W-1:0] c_DEPTH_Q = c_QCNT_W'(DEPTH);
    localparam logic [c_QCNT_W-1:0] c_QONE    = c_QCNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
    localparam logic [ADDR_W-1:0]   c_PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]    c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0]   r_pc;
    logic                r_pred [DEPTH];
    logic [ADDR_W-1:0]   r_alt  [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_QCNT_W-1:0] r_count;
    logic                r_q_full;
    logic                r_err_underflow;
    logic [CNT_W-1:0]    r_br_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    // ------------------------------------------------------------------------
    // Decision logic
    // ------------------------------------------------------------------------
    logic                w_empty;
    logic                w_pop;
    logic                w_head_pred;
    logic [ADDR_W-1:0]   w_head_alt;
    logic                w_mispredict;
    logic                w_hold;
    logic                w_push;
    logic [ADDR_W-1:0]   w_pc_seq;
    logic [ADDR_W-1:0]   w_alt_new;
    logic [ADDR_W-1:0]   w_next_pc;
    logic [c_QCNT_W-1:0] w_next_count;

    assign w_empty     = (r_count == '0);
    assign w_pop       = bus.res_valid & ~w_empty;
    assign w_head_pred = r_pred[r_head];
    assign w_head_alt  = r_alt[r_head];

    // Only a real pop can mispredict; a resolve against an empty queue is
    // reported through err_underflow instead.
    assign w_mispredict = w_pop & (w_head_pred != bus.res_taken);

    // A branch that cannot be queued must not be fetched past. When a pop
    // frees a slot in the same cycle, the branch goes straight in.
    assign w_hold = bus.stall | (r_q_full & bus.if_is_branch & ~w_pop);

    // Anything fetched in a mispredict cycle is on the wrong path.
    assign w_push = bus.if_is_branch & ~w_hold & ~w_mispredict;

    assign w_pc_seq  = r_pc + c_PC_STEP;

    // The alternate address is whichever path fetch did NOT follow.
    assign w_alt_new = bus.pred_taken ? w_pc_seq : bus.if_target;

    always_comb begin
        w_next_pc = w_pc_seq;
        if (w_mispredict) begin
            w_next_pc = w_head_alt;
        end else if (w_hold) begin
            w_next_pc = r_pc;
        end else if (bus.if_is_branch && bus.pred_taken) begin
            w_next_pc = bus.if_target;
        end
    end

    always_comb begin
        w_next_count = r_count;
        if (w_mispredict) begin
            w_next_count = '0;
        end else if (w_push && !w_pop) begin
            w_next_count = r_count + c_QONE;
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - c_QONE;
        end
    end

    // ------------------------------------------------------------------------
    // PC, queue control and status registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc            <= RESET_PC;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_q_full        <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            r_pc            <= w_next_pc;
            r_count         <= w_next_count;
            r_q_full        <= (w_next_count == c_DEPTH_Q);
            r_err_underflow <= bus.res_valid & w_empty;
            if (w_mispredict) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                // DEPTH is a power of two, so pointer overflow is the wrap.
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Queue storage. Entries are only read while counted as valid, so the
    // payload needs no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pred[r_tail] <= bus.pred_taken;
            r_alt[r_tail]  <= w_alt_new;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_pop && (r_br_cnt != c_CNT_MAX)) begin
                r_br_cnt <= r_br_cnt + c_CNT_ONE;
            end
            if (w_mispredict && (r_miss_cnt != c_CNT_MAX)) begin
                r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.pc            = r_pc;
    assign bus.flush         = w_mispredict;
    assign bus.upd_branch    = w_pop;
    assign bus.upd_taken     = w_pop & bus.res_taken;
    assign bus.q_full        = r_q_full;
    assign bus.err_underflow = r_err_underflow;
    assign bus.br_cnt        = r_br_cnt;
    assign bus.miss_cnt      = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_redirect_unit
//  Description : Directed self-checking bench for branch_redirect_unit with
//                RESET_PC = 0x100. One task per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_unit;

    localparam int          c_ADDR_W = 32;
    localparam int          c_CNT_W  = 16;
    localparam logic [31:0] c_RST_PC = 32'h100;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    branch_redirect_unit_if #(.ADDR_W(c_ADDR_W), .CNT_W(c_CNT_W)) bus ();

    branch_redirect_unit #(
        .ADDR_W   (c_ADDR_W),
        .DEPTH    (2),
        .CNT_W    (c_CNT_W),
        .RESET_PC (c_RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.stall        = 1'b0;
        bus.if_is_branch = 1'b0;
        bus.pred_taken   = 1'b0;
        bus.if_target    = '0;
        bus.res_valid    = 1'b0;
        bus.res_taken    = 1'b0;
    endtask

    // advance one clock; inputs and samples sit 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL rst_pc: got %h want %h", bus.pc, 32'h100); end
        checks++; if (bus.q_full !== 1'b0) begin errors++; $display("FAIL rst_qfull: got %b want 0", bus.q_full); end
        checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err_underflow); end
        checks++; if (bus.br_cnt !== 16'h0 || bus.miss_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", bus.br_cnt, bus.miss_cnt); end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL idle_pc%0d: got %h want %h", i, bus.pc, 32'h100 + 32'(4 * i)); end
        end
        checks++; if (bus.br_cnt !== 16'h0) begin errors++; $display("FAIL idle_brcnt: got %h want 0", bus.br_cnt); end
    endtask

    // branch at 0x104 predicted taken to 0x200, resolved after one more cycle
    task automatic taken_prefix();
        apply_reset();
        tick();
        bus.if_is_branch = 1'b1; bus.pred_taken = 1'b1; bus.if_target = 32'h200;
        tick();
        idle_inputs();
        checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL tk_pc: got %h want 200", bus.pc); end
        tick();
        bus.res_valid = 1'b1;
    endtask

    task automatic test_taken_correct();
        taken_prefix();
        bus.res_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL tkc_flush: got %b want 0", bus.flush); end
        checks++; if (bus.upd_branch !== 1'b1 || bus.upd_taken !== 1'b1) begin errors++; $display("FAIL tkc_upd: got %b%b want 11", bus.upd_branch, bus.upd_taken); end
        tick();
        idle_inputs();
        checks++; if (bus.pc !== 32'h208) begin errors++; $display("FAIL tkc_pc: got %h want 208", bus.pc); end
        checks++; if (bus.br_cnt !== 16'd1 || bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL tkc_cnt: got %h/%h want 1/0", bus.br_cnt, bus.miss_cnt); end
    endtask

    task automatic test_taken_mispredict();
        taken_prefix();
        bus.res_taken = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL tkm_flush: got %b want 1", bus.flush); end
        checks++; if (bus.upd_branch !== 1'b1 || bus.upd_taken !== 1'b0) begin errors++; $display("FAIL tkm_upd: got %b%b want 10", bus.upd_branch, bus.upd_taken); end
        tick();
        idle_inputs();
        checks++; if (bus.pc !== 32'h108) begin errors++; $display("FAIL tkm_pc: got %h want 108", bus.pc); end
        checks++; if (bus.br_cnt !== 16'd1 || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL tkm_cnt: got %h/%h want 1/1", bus.br_cnt, bus.miss_cnt); end
        // queue must now be empty: a resolve finds nothing to pop
        bus.res_valid = 1'b1;
        #1;
        checks++; if (bus.upd_branch !== 1'b0) begin errors++; $display("FAIL tkm_empty: got %b want 0", bus.upd_branch); end
        tick();
        idle_inputs();
    endtask

    task automatic test_stall_mispredict();
        apply_reset();
        bus.if_is_branch = 1'b1; bus.pred_taken = 1'b0; bus.if_target = 32'h300;
        tick();
        idle_inputs();
        checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL stm_pc0: got %h want 104", bus.pc); end
        bus.stall = 1'b1; bus.res_valid = 1'b1; bus.res_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL stm_flush: got %b want 1", bus.flush); end
        tick();
        bus.res_valid = 1'b0; bus.res_taken = 1'b0;
        checks++; if (bus.pc !== 32'h300) begin errors++; $display("FAIL stm_pc: got %h want 300", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL stm_miss: got %h want 1", bus.miss_cnt); end
        tick();
        checks++; if (bus.pc !== 32'h300) begin errors++; $display("FAIL stm_hold: got %h want 300", bus.pc); end
        idle_inputs();
    endtask

    task automatic test_queue_full();
        apply_reset();
        bus.if_is_branch = 1'b1; bus.pred_taken = 1'b0; bus.if_target = 32'h300;
        tick();
        bus.if_target = 32'h400;
        tick();
        checks++; if (bus.q_full !== 1'b1 || bus.pc !== 32'h108) begin errors++; $display("FAIL qf_fill: got full=%b pc=%h want 1/108", bus.q_full, bus.pc); end
        bus.pred_taken = 1'b1; bus.if_target = 32'h500;
        tick();
        checks++; if (bus.pc !== 32'h108) begin errors++; $display("FAIL qf_hold: got %h want 108", bus.pc); end
        // first branch resolves correctly; third branch enters the freed slot
        bus.res_valid = 1'b1; bus.res_taken = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.upd_branch !== 1'b1) begin errors++; $display("FAIL qf_pop: got flush=%b upd=%b want 0/1", bus.flush, bus.upd_branch); end
        tick();
        bus.if_is_branch = 1'b0;
        checks++; if (bus.pc !== 32'h500 || bus.q_full !== 1'b1) begin errors++; $display("FAIL qf_push: got pc=%h full=%b want 500/1", bus.pc, bus.q_full); end
        // second branch, predicted not taken, resolves not taken
        tick();
        checks++; if (bus.q_full !== 1'b0 || bus.pc !== 32'h504) begin errors++; $display("FAIL qf_pop2: got full=%b pc=%h want 0/504", bus.q_full, bus.pc); end
        // third branch (wrapped slot) was predicted taken; resolve not taken
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL qf_wrap_flush: got %b want 1", bus.flush); end
        tick();
        idle_inputs();
        checks++; if (bus.pc !== 32'h10C) begin errors++; $display("FAIL qf_wrap_pc: got %h want 10c", bus.pc); end
        checks++; if (bus.br_cnt !== 16'd3 || bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL qf_cnt: got %h/%h want 3/1", bus.br_cnt, bus.miss_cnt); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        bus.if_is_branch = 1'b1; bus.pred_taken = 1'b1; bus.if_target = 32'h700;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL mr_pc: got %h want 100", bus.pc); end
        tick();
        rst = 1'b0;
        bus.res_valid = 1'b1; bus.res_taken = 1'b0;
        #1;
        checks++; if (bus.upd_branch !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL mr_queue: got upd=%b flush=%b want 0/0", bus.upd_branch, bus.flush); end
        tick();
        idle_inputs();
    endtask

    task automatic test_underflow();
        apply_reset();
        bus.res_valid = 1'b1; bus.res_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.upd_branch !== 1'b0 || bus.upd_taken !== 1'b0) begin errors++; $display("FAIL uf_comb: got %b%b%b want 000", bus.flush, bus.upd_branch, bus.upd_taken); end
        tick();
        idle_inputs();
        checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse: got %b want 1", bus.err_underflow); end
        checks++; if (bus.br_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL uf_cnt: got %h/%h want 0/0", bus.br_cnt, bus.miss_cnt); end
        tick();
        checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL uf_end: got %b want 0", bus.err_underflow); end
    endtask

    task automatic test_saturation();
        apply_reset();
        bus.if_is_branch = 1'b1; bus.pred_taken = 1'b0; bus.if_target = 32'h300;
        tick();
        // one entry in flight: each cycle pops it correctly and pushes a new one
        bus.res_valid = 1'b1; bus.res_taken = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        checks++; if (bus.br_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", bus.br_cnt); end
        tick();
        checks++; if (bus.br_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.br_cnt); end
        checks++; if (bus.miss_cnt !== 16'h0) begin errors++; $display("FAIL sat_miss: got %h want 0", bus.miss_cnt); end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_taken_correct();
        test_taken_mispredict();
        test_stall_mispredict();
        test_queue_full();
        test_mid_reset();
        test_underflow();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
